cell_draw_engine: RTL
=====================

Name: cell_draw_engine

Overview:
- Downstream of the frame tracker.
- Drives the tracker's scan-advance enable and watches its diff/obj_code/x/y outputs.
- On a changed cell, stalls the scan and streams that cell's pixel rectangle as RGB565 writes over a valid/ready pixel interface toward the LCD/framebuffer writer.
- Screen is 320x240: a 16x12 grid of 20x20-pixel cells.

Parameters:
- GRID_W, 16, cells per row
- GRID_H, 12, cells per column
- CELL_PX, 20, cell edge in pixels; px_x/px_y widths derived as $clog2(GRID_W*CELL_PX) and $clog2(GRID_H*CELL_PX)

Ports:
- clk  input  1  system clock
- rst  input  1  reset, synchronous, active-high
- run  input  1  permit scanning (low holds the tracker, e.g. during LCD init)
- diff  input  1  tracker: current cell changed
- obj_code  input  3  tracker: new object code (obj_code_t)
- x  input  4  tracker: current cell column
- y  input  4  tracker: current cell row
- scan_en  output  1  enable to tracker
- busy  output  1  drawing a cell
- frame_done  output  1  one-cycle pulse when the scan wraps
- px_valid  output  1  pixel write valid
- px_ready  input  1  pixel sink ready
- px_x  output  9  pixel column
- px_y  output  8  pixel row
- px_color  output  16  RGB565 colour

Behaviour:
- Reset: state=SCAN; scan_en, busy, frame_done, px_valid = 0; px_x, px_y, px_color, internal counters = 0.
- Reset asserted mid-DRAW aborts the cell. px_valid is 0 from the next edge and no partial-cell resume occurs.

States:
- SCAN
  - scan_en = run (combinational).
  - Edge with scan_en=1 and diff=1: latch x, y, obj_code; clear col_cnt/row_cnt; go DRAW. The tracker advances on the same edge, so each cell is captured exactly once.
  - Edge with scan_en=1, x=GRID_W-1, y=GRID_H-1: frame_done=1 for the next cycle. This also applies if that same cell has diff=1.
- DRAW
  - scan_en=0, busy=1.
  - px_valid=1 from the first cycle after capture.
  - px_x = cx*CELL_PX + col_cnt; px_y = cy*CELL_PX + row_cnt.
  - Intermediate products are at least 9 bits; no truncation for in-range x/y.
  - Raster order: col_cnt inner 0..CELL_PX-1, row_cnt outer.
  - Counters advance only on a handshake (px_valid & px_ready).
  - While px_valid & !px_ready, px_x, px_y and px_color hold stable.
  - Handshake on col=CELL_PX-1, row=CELL_PX-1 (400th pixel): px_valid=0 and go SCAN next cycle. scan_en resumes that cycle when run=1.
  - run is ignored in DRAW; a cell always completes.
- Colour map (package constants):
  - blank=0x0000
  - snake_head=0x07E0
  - snake_body=0x03E0
  - apple_c=0xF800
  - border_c=0x8410
  - undefined codes 5..7 draw as blank.
- Throughput: with px_ready tied high, exactly CELL_PX*CELL_PX DRAW cycles per cell, plus 1 SCAN cycle before the next capture.
- diff is ignored when scan_en=0.

Optional Feature:
- CELL_DRAW_GRID_LINES_EN
- Defined: for cells with code blank (and undefined codes), pixels with col_cnt==0 or row_cnt==0 use GRID_COLOR 0x2104; all other codes unaffected.
- Undefined: blank cells are solid 0x0000.
- Pixel count and timing are identical either way.

Decomposition:
- snake_pkg: obj_code_t enum (moved out of file scope and shared with the frame tracker), the RGB565 colour constants, GRID_COLOR, grid/cell size defaults.
- One sub-module: cell_color_lut, a combinational obj_code (plus edge flag when the feature is enabled) to RGB565 lookup.

Test Plan:
- Scan only: run=1, diff=0 for 192 cycles, px_ready=1 → scan_en=1 throughout. frame_done pulses once, the cycle after x=15,y=11 is presented. px_valid never 1.
- Single cell: diff=1 at x=3,y=2, obj_code=apple_c, px_ready=1 → next cycle px_valid=1, px_x=60, px_y=40, px_color=0xF800. Last pixel is px_x=79, px_y=59 on the 400th cycle. scan_en=0 throughout DRAW.
- Backpressure: px_ready toggling 1,0,0,1… during a head cell at x=15,y=11 → outputs stable during stalls. Exactly 400 handshakes, final px_x=319, px_y=239. frame_done pulses after the cell's capture edge.
- Run gating: run=0 in SCAN with diff=1 → no capture, scan_en=0. Set run=0 mid-DRAW → the cell still completes all 400 pixels.
- Reset mid-draw: assert rst after 123 handshakes → next cycle px_valid=0, busy=0, state SCAN, px_x=px_y=0. After release, the next diff draws from pixel 0.
- Undefined code plus feature: obj_code=6 at x=0,y=0 → with CELL_DRAW_GRID_LINES_EN, pixel (0,0) is 0x2104 and (5,5) is 0x0000. Without the macro, all 400 pixels are 0x0000.

Source files
------------

// File: rtl/snake_pkg.sv
// Shared types and constants for the snake display pipeline (frame tracker and cell draw engine).
package snake_pkg;

  localparam int GRID_W_DEF  = 16;
  localparam int GRID_H_DEF  = 12;
  localparam int CELL_PX_DEF = 20;

  typedef enum logic [2:0] {
    OBJ_BLANK      = 3'd0,
    OBJ_SNAKE_HEAD = 3'd1,
    OBJ_SNAKE_BODY = 3'd2,
    OBJ_APPLE      = 3'd3,
    OBJ_BORDER     = 3'd4
  } obj_code_t;

  typedef enum logic {
    ST_SCAN = 1'b0,
    ST_DRAW = 1'b1
  } draw_state_t;

  localparam logic [15:0] COLOR_BLANK      = 16'h0000;
  localparam logic [15:0] COLOR_SNAKE_HEAD = 16'h07E0;
  localparam logic [15:0] COLOR_SNAKE_BODY = 16'h03E0;
  localparam logic [15:0] COLOR_APPLE      = 16'hF800;
  localparam logic [15:0] COLOR_BORDER     = 16'h8410;
  localparam logic [15:0] GRID_COLOR       = 16'h2104;

endpackage

// File: rtl/cell_draw_engine_color_lut.sv
// Object code to RGB565 lookup. With CELL_DRAW_GRID_LINES_EN defined, blank cells
// get a grid line on their top row and left column.
module cell_color_lut
  import snake_pkg::*;
(
  input  logic [2:0]  obj_code,
`ifdef CELL_DRAW_GRID_LINES_EN
  input  logic        edge_px,
`endif
  output logic [15:0] color
);

  logic [15:0] blank_color;

`ifdef CELL_DRAW_GRID_LINES_EN
  assign blank_color = edge_px ? GRID_COLOR : COLOR_BLANK;
`else
  assign blank_color = COLOR_BLANK;
`endif

  // Undefined codes fall through to the blank colour.
  always_comb begin
    color = blank_color;
    case (obj_code)
      OBJ_SNAKE_HEAD: color = COLOR_SNAKE_HEAD;
      OBJ_SNAKE_BODY: color = COLOR_SNAKE_BODY;
      OBJ_APPLE:      color = COLOR_APPLE;
      OBJ_BORDER:     color = COLOR_BORDER;
      default:        color = blank_color;
    endcase
  end

endmodule

// File: rtl/cell_draw_engine.sv
// Scans the frame tracker and streams each changed cell as a CELL_PX x CELL_PX RGB565 rectangle.
// Optional feature macro: CELL_DRAW_GRID_LINES_EN (grid lines on blank cells).
module cell_draw_engine
  import snake_pkg::*;
#(
  parameter int GRID_W  = GRID_W_DEF,
  parameter int GRID_H  = GRID_H_DEF,
  parameter int CELL_PX = CELL_PX_DEF,
  localparam int PX_W   = $clog2(GRID_W * CELL_PX),
  localparam int PY_W   = $clog2(GRID_H * CELL_PX),
  localparam int CNT_W  = $clog2(CELL_PX)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            run,
  input  logic            diff,
  input  logic [2:0]      obj_code,
  input  logic [3:0]      x,
  input  logic [3:0]      y,
  output logic            scan_en,
  output logic            busy,
  output logic            frame_done,
  output logic            px_valid,
  input  logic            px_ready,
  output logic [PX_W-1:0] px_x,
  output logic [PY_W-1:0] px_y,
  output logic [15:0]     px_color
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CELL_PX - 1);
  localparam logic [3:0]       X_LAST   = 4'(GRID_W - 1);
  localparam logic [3:0]       Y_LAST   = 4'(GRID_H - 1);

  draw_state_t      state_q, state_d;
  logic [3:0]       cx_q, cx_d;
  logic [3:0]       cy_q, cy_d;
  logic [2:0]       code_q, code_d;
  logic [CNT_W-1:0] col_q, col_d;
  logic [CNT_W-1:0] row_q, row_d;
  logic             frame_done_q, frame_done_d;
  logic [15:0]      lut_color;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_SCAN;
      cx_q         <= '0;
      cy_q         <= '0;
      code_q       <= '0;
      col_q        <= '0;
      row_q        <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cx_q         <= cx_d;
      cy_q         <= cy_d;
      code_q       <= code_d;
      col_q        <= col_d;
      row_q        <= row_d;
      frame_done_q <= frame_done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cx_d         = cx_q;
    cy_d         = cy_q;
    code_d       = code_q;
    col_d        = col_q;
    row_d        = row_q;
    // The tracker advances on every scan_en edge, so the wrap is seen exactly once per frame.
    frame_done_d = scan_en && (x == X_LAST) && (y == Y_LAST);
    case (state_q)
      ST_SCAN: begin
        if (scan_en && diff) begin
          state_d = ST_DRAW;
          cx_d    = x;
          cy_d    = y;
          code_d  = obj_code;
          col_d   = '0;
          row_d   = '0;
        end
      end
      ST_DRAW: begin
        if (px_ready) begin
          if (col_q == CNT_LAST) begin
            col_d = '0;
            if (row_q == CNT_LAST) begin
              row_d   = '0;
              state_d = ST_SCAN;
            end else begin
              row_d = row_q + 1'b1;
            end
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      default: state_d = ST_SCAN;
    endcase
  end

  always_comb begin
    scan_en    = run && (state_q == ST_SCAN);
    busy       = (state_q == ST_DRAW);
    px_valid   = busy;
    frame_done = frame_done_q;
  end

  // Pixel address and colour come straight from held registers, so they stay stable under backpressure.
  assign px_x = PX_W'(cx_q) * PX_W'(CELL_PX) + PX_W'(col_q);
  assign px_y = PY_W'(cy_q) * PY_W'(CELL_PX) + PY_W'(row_q);
  assign px_color = px_valid ? lut_color : 16'h0000;

  cell_color_lut u_color_lut (
    .obj_code (code_q),
`ifdef CELL_DRAW_GRID_LINES_EN
    .edge_px  ((col_q == '0) || (row_q == '0)),
`endif
    .color    (lut_color)
  );

endmodule
